// File: rtl/gen_fifo_drain.sv
// Read-side drain for gen_fifo: pops the FIFO head into a 2-entry head/skid buffer
// and presents it as a registered valid/ready stream.
module gen_fifo_drain #(
    parameter int DW = 64
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          flush,
    input  logic          fifo_empty,
    input  logic [DW-1:0] data_pop,
    output logic          fifo_pop,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic [1:0]    cnt;
    logic [DW-1:0] buf0;
    logic [DW-1:0] buf1;
    logic          take;

    // Pop decision uses only registered occupancy, so out_ready never reaches fifo_pop.
    assign fifo_pop  = ~fifo_empty & ~flush & ~RST & (cnt != 2'd2);
    assign out_valid = (cnt != 2'd0);
    assign out_data  = buf0;
    assign take      = out_valid & out_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt  <= 2'd0;
            buf0 <= '0;
            buf1 <= '0;
        end else if (flush) begin
            cnt <= 2'd0;
        end else begin
            case ({take, fifo_pop})
                2'b01: begin
                    if (cnt == 2'd0) buf0 <= data_pop;
                    else             buf1 <= data_pop;
                    cnt <= cnt + 2'd1;
                end
                2'b10: begin
                    buf0 <= buf1;
                    cnt  <= cnt - 2'd1;
                end
                // Only reachable at cnt==1: replace the head, occupancy unchanged.
                2'b11: buf0 <= data_pop;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gen_fifo_drain.sv
// Bench for gen_fifo_drain: a queue-based FIFO and buffer model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_gen_fifo_drain;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        flush = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [63:0] data_pop = '0;
    logic        fifo_pop;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;

    gen_fifo_drain #(.DW(64)) dut (
        .CLK(CLK), .RST(RST), .flush(flush), .fifo_empty(fifo_empty),
        .data_pop(data_pop), .fifo_pop(fifo_pop), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    int          pop_cnt = 0;
    logic        chk_en = 1'b0;
    logic        m_take = 1'b0;
    logic        m_pop = 1'b0;
    logic [63:0] fq[$];
    logic [63:0] mq[$];
    logic [63:0] got[$];
    logic [63:0] want[$];
    logic        pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fifo_if();
        fifo_empty = (fq.size() == 0);
        data_pop   = fifo_empty ? 64'h0 : fq[0];
    endtask

    task automatic push(input logic [63:0] v);
        fq.push_back(v);
        fifo_if();
    endtask

    // Model: mq holds what the consumer should see, in order; fq is the FIFO.
    always @(negedge CLK) begin
        if (chk_en) begin
            if (RST) begin
                m_take = 1'b0;
                m_pop  = 1'b0;
                chk("rst_valid", {63'd0, out_valid}, 64'd0);
                chk("rst_data", out_data, 64'd0);
                chk("rst_pop", {63'd0, fifo_pop}, 64'd0);
            end else begin
                m_take = (mq.size() != 0) && out_ready;
                m_pop  = (fq.size() != 0) && !flush && (mq.size() < 2);
                chk("valid", {63'd0, out_valid}, {63'd0, mq.size() != 0});
                if (mq.size() != 0) chk("data", out_data, mq[0]);
                chk("pop", {63'd0, fifo_pop}, {63'd0, m_pop});
                if (fifo_pop) pop_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        if (RST) begin
            mq.delete();
        end else if (flush) begin
            if (m_take) got.push_back(mq[0]);
            mq.delete();
            fq.delete();
        end else begin
            if (m_take) got.push_back(mq.pop_front());
            if (m_pop)  mq.push_back(fq.pop_front());
        end
        fifo_if();
    endtask

    task automatic run_until(input int n, input int maxc, input string name);
        int c = 0;
        while (got.size() < n && c < maxc) begin
            tick();
            c++;
        end
        chk({name, "_done"}, {63'd0, got.size() >= n}, 64'd1);
    endtask

    task automatic chk_seq(input string name);
        chk({name, "_len"}, 64'(got.size()), 64'(want.size()));
        for (int i = 0; i < want.size() && i < got.size(); i++)
            chk($sformatf("%s[%0d]", name, i), got[i], want[i]);
    endtask

    initial begin
        int base;
        #1 chk_en = 1'b1;

        // Reset held with a non-empty FIFO
        push(64'h01); push(64'h02);
        tick(); tick(); tick();
        chk("t1_rst_pop", {63'd0, fifo_pop}, 64'd0);
        chk("t1_rst_valid", {63'd0, out_valid}, 64'd0);
        RST = 1'b0;
        #1 chk("t1_pop_after_rst", {63'd0, fifo_pop}, 64'd1);
        out_ready = 1'b1;
        run_until(2, 10, "t1");
        want = '{64'h01, 64'h02};
        chk_seq("t1_seq");

        // Streaming with no bubbles
        got.delete();
        for (int i = 0; i < 8; i++) push(64'h11 + 64'(i));
        tick();
        chk("t2_first_valid", {63'd0, out_valid}, 64'd1);
        chk("t2_first_data", out_data, 64'h11);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("t2_data%0d", i), out_data, 64'h11 + 64'(i));
            chk($sformatf("t2_valid%0d", i), {63'd0, out_valid}, 64'd1);
        end
        run_until(8, 5, "t2");
        want = '{64'h11, 64'h12, 64'h13, 64'h14, 64'h15, 64'h16, 64'h17, 64'h18};
        chk_seq("t2_seq");

        // Backpressure
        got.delete();
        out_ready = 1'b0;
        base = pop_cnt;
        for (int i = 0; i < 5; i++) push(64'h31 + 64'(i));
        for (int i = 0; i < 6; i++) tick();
        chk("t3_pops", 64'(pop_cnt - base), 64'd2);
        chk("t3_pop_low", {63'd0, fifo_pop}, 64'd0);
        chk("t3_data_hold", out_data, 64'h31);
        out_ready = 1'b1;
        run_until(5, 20, "t3");
        want = '{64'h31, 64'h32, 64'h33, 64'h34, 64'h35};
        chk_seq("t3_seq");

        // Toggling ready
        got.delete();
        want.delete();
        for (int i = 0; i < 20; i++) begin
            push(64'h40 + 64'(i));
            want.push_back(64'h40 + 64'(i));
        end
        for (int k = 0; got.size() < 20 && k < 100; k++) begin
            out_ready = pat[k % 5];
            tick();
        end
        chk_seq("t4_seq");

        // Flush with the buffer full
        out_ready = 1'b0;
        push(64'h51); push(64'h52); push(64'h53);
        tick(); tick(); tick();
        chk("t5_full_pop", {63'd0, fifo_pop}, 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_flush_valid", {63'd0, out_valid}, 64'd0);
        got.delete();
        tick(); tick();
        push(64'hAA);
        out_ready = 1'b1;
        run_until(1, 10, "t5");
        want = '{64'hAA};
        chk_seq("t5_seq");

        // Empty FIFO, consumer ready
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t6_pop", {63'd0, fifo_pop}, 64'd0);
            chk("t6_valid", {63'd0, out_valid}, 64'd0);
        end

        // Reset mid-stream
        got.delete();
        for (int i = 0; i < 4; i++) push(64'h71 + 64'(i));
        tick(); tick();
        RST = 1'b1;
        #1;
        chk("t7_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("t7_rst_data", out_data, 64'd0);
        chk("t7_rst_pop", {63'd0, fifo_pop}, 64'd0);
        tick();
        RST = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("t7_fifo_drained", 64'(fq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
